// File: rtl/sb_pulse_period_meter.sv
// sb_pulse_period_meter
// Measures the high width, low width or rising-to-rising period of an
// asynchronous input in prescaled clk ticks. The input is synchronised,
// edge-detected and timed by a two-state FSM (IDLE / MEAS). Each finished
// measurement is published on count/overflow together with a 1-cycle strobe.
//
// Output strobe semantics: valid is high for exactly one clk cycle per
// completed measurement, and count/overflow change only in that same cycle
// (or on reset). There is no back-pressure: a consumer that needs the
// result must capture it while valid is high, because a later result
// replaces it. When a measurement is aborted, no strobe is produced.
module sb_pulse_period_meter #(
  parameter int CNT_W       = 14,
  parameter int PRESCALE    = 4,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [1:0]       mode,
  input  logic             ip_signal,
  output logic [CNT_W-1:0] count,
  output logic             valid,
  output logic             overflow,
  output logic             busy,
  output logic             dbg_state_o
);

  localparam int PRE_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(PRESCALE - 1);
  localparam logic [CNT_W-1:0] ACC_MAX  = {CNT_W{1'b1}};

  typedef enum logic {
    IDLE = 1'b0,
    MEAS = 1'b1
  } state_t;

  state_t                 state_q, state_d;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s_dly_q;
  logic [1:0]             mode_q, mode_d;
  logic [PRE_W-1:0]       pre_q, pre_d;
  logic [CNT_W-1:0]       acc_q, acc_d;
  logic                   sat_q, sat_d;
  logic [CNT_W-1:0]       count_q, count_d;
  logic                   ovf_q, ovf_d;
  logic                   valid_q, valid_d;

  logic                   s_sync;
  logic                   rise;
  logic                   fall;
  logic                   start_edge;
  logic                   stop_edge;
  logic                   tick;
  logic                   acc_full;
  logic                   sat_now;
  logic [CNT_W-1:0]       acc_inc;
  logic [PRE_W-1:0]       pre_next;
  logic                   abort;

  // Synchroniser chain and one-cycle delayed copy for edge detection.
  // The delayed copy resets to 0, so an input already high at reset
  // release is seen as a rising edge once it has passed the chain.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      sync_q  <= '0;
      s_dly_q <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], ip_signal};
      s_dly_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign s_sync = sync_q[SYNC_STAGES-1];
  assign rise   = s_sync & ~s_dly_q;
  assign fall   = ~s_sync & s_dly_q;

  // Start edge uses the live mode (only consulted in IDLE); the stop edge
  // uses the mode captured while idle, so a measurement keeps its meaning.
  // mode 00: rise..fall, mode 01: fall..rise, mode 1x: rise..rise.
  assign start_edge = (mode == 2'b01) ? fall : rise;
  assign stop_edge  = (mode_q == 2'b00) ? fall : rise;

  // Prescaler tick and saturating accumulator step.
  assign tick     = (pre_q == PRE_LAST);
  assign acc_full = (acc_q == ACC_MAX);
  assign sat_now  = tick & acc_full;
  assign acc_inc  = (tick && !acc_full) ? acc_q + CNT_W'(1) : acc_q;
  assign pre_next = tick ? '0 : pre_q + PRE_W'(1);

  // Disabling, or changing mode mid-measurement, abandons the measurement.
  assign abort = !en || (mode != mode_q);

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      mode_q  <= 2'b00;
      pre_q   <= '0;
      acc_q   <= '0;
      sat_q   <= 1'b0;
      count_q <= '0;
      ovf_q   <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      pre_q   <= pre_d;
      acc_q   <= acc_d;
      sat_q   <= sat_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
      valid_q <= valid_d;
    end
  end

  // Next-state and datapath update. An abort takes priority over a stop
  // edge arriving in the same cycle, so an aborted cycle never strobes.
  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    pre_d   = pre_q;
    acc_d   = acc_q;
    sat_d   = sat_q;
    count_d = count_q;
    ovf_d   = ovf_q;
    valid_d = 1'b0;

    case (state_q)
      IDLE: begin
        mode_d = mode;
        pre_d  = '0;
        acc_d  = '0;
        sat_d  = 1'b0;
        if (en && start_edge) begin
          state_d = MEAS;
        end
      end

      MEAS: begin
        if (abort) begin
          state_d = IDLE;
          pre_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
        end else if (stop_edge) begin
          // The tick coinciding with the stop edge still counts.
          valid_d = 1'b1;
          count_d = acc_inc;
          ovf_d   = sat_q | sat_now;
          pre_d   = '0;
          acc_d   = '0;
          sat_d   = 1'b0;
          // In period mode this rising edge also starts the next period.
          if (!mode_q[1]) begin
            state_d = IDLE;
          end
        end else begin
          pre_d = pre_next;
          acc_d = acc_inc;
          sat_d = sat_q | sat_now;
        end
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  assign count       = count_q;
  assign valid       = valid_q;
  assign overflow    = ovf_q;
  assign busy        = (state_q == MEAS);
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_sb_pulse_period_meter.sv
// Bench for sb_pulse_period_meter: table of single-measurement vectors plus
// hand-written sequences for period mode, aborts, saturation and reset.
module tb_sb_pulse_period_meter;

  localparam int W  = 14;
  localparam int W4 = 4;

  // Clock / reset
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  logic          en   = 1'b0;
  logic [1:0]    mode = 2'b00;
  logic          ip   = 1'b0;
  logic          ip4  = 1'b0;

  logic [W-1:0]  count;
  logic          valid, overflow, busy, dbg_state;
  logic [W4-1:0] count4;
  logic          valid4, overflow4, busy4, dbg_state4;

  sb_pulse_period_meter #(.CNT_W(W), .PRESCALE(4), .SYNC_STAGES(2)) dut (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ip_signal(ip),
    .count(count), .valid(valid), .overflow(overflow), .busy(busy),
    .dbg_state_o(dbg_state)
  );

  sb_pulse_period_meter #(.CNT_W(W4), .PRESCALE(4), .SYNC_STAGES(2)) dut4 (
    .clk(clk), .rst(rst), .en(en), .mode(mode), .ip_signal(ip4),
    .count(count4), .valid(valid4), .overflow(overflow4), .busy(busy4),
    .dbg_state_o(dbg_state4)
  );

  int checks = 0;
  int errors = 0;

  // Scoreboards: expected {overflow, count} per strobe, in order.
  logic [W:0]  exp_q[$];
  logic [W4:0] exp4_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d", name, act, exp);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Strobe monitor for the wide instance.
  logic valid_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && valid) begin
      logic [W:0] e;
      checks++;
      if (valid_prev) begin
        errors++;
        $display("FAIL valid_width strobe held for 2+ cycles, required 1");
      end else if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid count=%0d overflow=%0b, required no strobe", count, overflow);
      end else begin
        e = exp_q.pop_front();
        if ({overflow, count} !== e) begin
          errors++;
          $display("FAIL strobe_result count=%0d overflow=%0b required count=%0d overflow=%0b",
                   count, overflow, e[W-1:0], e[W]);
        end
      end
    end
    valid_prev = valid;
  end

  // Strobe monitor for the 4-bit instance.
  logic valid4_prev = 1'b0;
  always @(negedge clk) begin
    if (!rst && valid4) begin
      logic [W4:0] e;
      checks++;
      if (valid4_prev) begin
        errors++;
        $display("FAIL valid4_width strobe held for 2+ cycles, required 1");
      end else if (exp4_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_valid4 count=%0d overflow=%0b, required no strobe", count4, overflow4);
      end else begin
        e = exp4_q.pop_front();
        if ({overflow4, count4} !== e) begin
          errors++;
          $display("FAIL strobe4_result count=%0d overflow=%0b required count=%0d overflow=%0b",
                   count4, overflow4, e[W4-1:0], e[W4]);
        end
      end
    end
    valid4_prev = valid4;
  end

  // Single-measurement vector: ip = lvl0 for len0, ~lvl0 for len1, lvl0 for len2.
  typedef struct {
    logic [1:0]   mode;
    logic         lvl0;
    int           len0;
    int           len1;
    int           len2;
    logic [W-1:0] exp_count;
  } vec_t;

  vec_t vecs[8];

  task automatic quiesce(input logic [1:0] m, input logic lvl);
    en   = 1'b0;
    ip   = lvl;
    ip4  = 1'b0;
    mode = m;
    cyc(6);
    en = 1'b1;
  endtask

  task automatic run_vec(input vec_t v, input int idx);
    quiesce(v.mode, v.lvl0);
    exp_q.push_back({1'b0, v.exp_count});
    cyc(v.len0);
    ip = ~v.lvl0;
    if (v.len1 >= 8) begin
      cyc(v.len1 / 2);
      check($sformatf("vec%0d_busy_mid", idx), busy, 1);
      cyc(v.len1 - v.len1 / 2);
    end else begin
      cyc(v.len1);
    end
    ip = v.lvl0;
    cyc(v.len2);
    check($sformatf("vec%0d_busy_end", idx), busy, 0);
    check($sformatf("vec%0d_missing_valid", idx), exp_q.size(), 0);
    check($sformatf("vec%0d_count", idx), count, v.exp_count);
  endtask

  initial begin
    vecs[0] = '{2'b00, 1'b0, 4, 40, 8, 14'd10};
    vecs[1] = '{2'b00, 1'b0, 4, 17, 8, 14'd4};
    vecs[2] = '{2'b00, 1'b0, 4,  3, 8, 14'd0};
    vecs[3] = '{2'b00, 1'b0, 4,  4, 8, 14'd1};
    vecs[4] = '{2'b01, 1'b1, 4, 20, 8, 14'd5};
    vecs[5] = '{2'b01, 1'b1, 4,  9, 8, 14'd2};
    vecs[6] = '{2'b00, 1'b0, 4,  1, 8, 14'd0};
    vecs[7] = '{2'b01, 1'b1, 4,  1, 8, 14'd0};

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_count", count, 0);
    check("rst_valid", valid, 0);
    check("rst_overflow", overflow, 0);
    check("rst_busy", busy, 0);
    cyc(3);
    rst = 1'b0;
    cyc(3);
    check("post_rst_busy", busy, 0);
    check("post_rst_count4", count4, 0);

    // Table-driven single measurements
    for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

    // Period mode: 12 high / 28 low, results only from the 2nd rise onward
    quiesce(2'b10, 1'b0);
    for (int i = 0; i < 3; i++) begin
      if (i > 0) exp_q.push_back({1'b0, 14'd10});
      ip = 1'b1;
      cyc(12);
      ip = 1'b0;
      cyc(28);
      check($sformatf("period%0d_busy", i), busy, 1);
    end
    check("period_missing_valid", exp_q.size(), 0);
    check("period_count", count, 10);
    en = 1'b0;
    cyc(2);
    check("period_disable_busy", busy, 0);

    // Enable dropped mid-pulse: no strobe, count holds, then a clean pulse
    quiesce(2'b00, 1'b0);
    exp_q.push_back({1'b0, 14'd6});
    ip = 1'b1;
    cyc(24);
    ip = 1'b0;
    cyc(8);
    check("pre_abort_count", count, 6);
    ip = 1'b1;
    cyc(20);
    check("abort_busy_before", busy, 1);
    en = 1'b0;
    cyc(20);
    ip = 1'b0;
    cyc(8);
    check("abort_busy", busy, 0);
    check("abort_count_held", count, 6);
    en = 1'b1;
    cyc(4);
    exp_q.push_back({1'b0, 14'd10});
    ip = 1'b1;
    cyc(40);
    ip = 1'b0;
    cyc(8);
    check("reenable_missing_valid", exp_q.size(), 0);
    check("reenable_count", count, 10);

    // Mode change mid-measurement aborts without a strobe
    quiesce(2'b00, 1'b0);
    ip = 1'b1;
    cyc(10);
    check("modechg_busy_before", busy, 1);
    mode = 2'b01;
    cyc(2);
    check("modechg_busy", busy, 0);
    check("modechg_count_held", count, 10);
    ip = 1'b0;
    cyc(8);

    // Saturation on the 4-bit build, then a short clean pulse
    quiesce(2'b00, 1'b0);
    exp4_q.push_back({1'b1, 4'd15});
    ip4 = 1'b1;
    cyc(100);
    ip4 = 1'b0;
    cyc(8);
    check("sat_missing_valid", exp4_q.size(), 0);
    check("sat_count", count4, 15);
    check("sat_overflow", overflow4, 1);
    exp4_q.push_back({1'b0, 4'd2});
    ip4 = 1'b1;
    cyc(8);
    ip4 = 1'b0;
    cyc(8);
    check("unsat_missing_valid", exp4_q.size(), 0);
    check("unsat_count", count4, 2);
    check("unsat_overflow", overflow4, 0);

    // Asynchronous reset mid-measurement, input held high through release
    quiesce(2'b00, 1'b0);
    ip = 1'b1;
    cyc(10);
    check("rst_mid_busy_before", busy, 1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check("rst_mid_count", count, 0);
    check("rst_mid_valid", valid, 0);
    check("rst_mid_overflow", overflow, 0);
    check("rst_mid_busy", busy, 0);
    check("rst_mid_state", dbg_state, 0);
    check("rst_mid_count4", count4, 0);
    @(negedge clk);
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.push_back({1'b0, 14'd5});
    repeat (4) @(posedge clk);
    #1;
    check("rst_release_busy", busy, 1);
    repeat (16) @(posedge clk);
    #1 ip = 1'b0;
    cyc(8);
    check("rst_release_missing_valid", exp_q.size(), 0);
    check("rst_release_count", count, 5);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
